// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode constants and hazard controller state type
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_IW = 32'h00000013;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2,
    ST_MWAIT = 2'd3
  } hz_state_t;

endpackage

// File: rtl/rv32i_reg_use.sv
// rtl/rv32i_reg_use.sv - source register fields and usage flags of an RV32I instruction word
module rv32i_reg_use
  import rv32i_pkg::*;
(
  input  logic [31:0] i_iw,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic        o_rs1_used,
  output logic        o_rs2_used
);

  logic [6:0] w_opcode;
  logic       w_unused_bits;

  assign w_opcode      = i_iw[6:0];
  assign o_rs1         = i_iw[19:15];
  assign o_rs2         = i_iw[24:20];
  assign w_unused_bits = &{i_iw[31:25], i_iw[14:7]};

  always_comb begin
    o_rs1_used = 1'b0;
    o_rs2_used = 1'b0;
    case (w_opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: o_rs1_used = 1'b1;
      OP_LUI, OP_AUIPC, OP_JAL: begin
        o_rs1_used = 1'b0;
        o_rs2_used = 1'b0;
      end
      default: begin
        o_rs1_used = 1'b0;
        o_rs2_used = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_hazard_ctl.sv
// rtl/rv32i_hazard_ctl.sv - ID/EX/MEM stall, flush and redirect sequencing with event counters
module rv32i_hazard_ctl
  import rv32i_pkg::*;
#(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_id_iw,
  input  logic [31:0]      i_ex_iw,
  input  logic             i_ex_wb_en,
  input  logic [4:0]       i_ex_wb_reg,
  input  logic             i_ex_take,
  input  logic [31:0]      i_ex_target,
  input  logic             i_mem_busy,
  input  logic             i_cnt_clr,
  output logic             o_pc_sel,
  output logic [31:0]      o_pc_target,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_flush_id,
  output logic             o_bubble_ex,
  output logic             o_stall_ex,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic             o_mem_timeout
);

  localparam int              INIT_W    = $clog2(INIT_CYCLES + 1);
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES - 1);
  localparam int              TO_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(MEM_TIMEOUT);

  hz_state_t         r_state;
  hz_state_t         w_next;
  logic [INIT_W-1:0] r_init_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [TO_W-1:0]   w_to_next;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              r_mem_timeout;

  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_rs1_used;
  logic       w_rs2_used;
  logic       w_load_use;
  logic       w_busy_rule;
  logic       w_take_rule;
  logic       w_lu_rule;
  logic       w_unused_ex;

  rv32i_reg_use u_id_use (
    .i_iw       (i_id_iw),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used)
  );

  assign w_unused_ex = &i_ex_iw[31:7];
  assign w_load_use  = (i_ex_iw[6:0] == OP_LOAD) && i_ex_wb_en && (i_ex_wb_reg != 5'd0) &&
                       ((w_rs1_used && (w_rs1 == i_ex_wb_reg)) ||
                        (w_rs2_used && (w_rs2 == i_ex_wb_reg)));
  assign w_to_next   = (r_to_cnt == TO_MAX) ? TO_MAX : r_to_cnt + TO_W'(1);

  // Priority: memory freeze, then redirect (suppressed in REDIR), then load-use.
  always_comb begin
    w_next      = r_state;
    w_busy_rule = 1'b0;
    w_take_rule = 1'b0;
    w_lu_rule   = 1'b0;
    o_pc_sel    = 1'b0;
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_flush_id  = 1'b0;
    o_bubble_ex = 1'b0;
    o_stall_ex  = 1'b0;
    if (i_reset || (r_state == ST_INIT)) begin
      o_stall_if  = 1'b1;
      o_bubble_ex = 1'b1;
      w_next      = (r_init_cnt == '0) ? ST_RUN : ST_INIT;
    end else if (i_mem_busy) begin
      w_busy_rule = 1'b1;
      o_stall_if  = 1'b1;
      o_stall_id  = 1'b1;
      o_stall_ex  = 1'b1;
      w_next      = ST_MWAIT;
    end else if (i_ex_take && (r_state != ST_REDIR)) begin
      w_take_rule = 1'b1;
      o_pc_sel    = 1'b1;
      o_flush_id  = 1'b1;
      o_bubble_ex = 1'b1;
      w_next      = ST_REDIR;
    end else begin
      w_lu_rule   = w_load_use;
      o_stall_if  = w_load_use;
      o_stall_id  = w_load_use;
      o_bubble_ex = w_load_use;
      w_next      = ST_RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_INIT;
      r_init_cnt    <= INIT_LOAD;
      r_to_cnt      <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_to_cnt <= w_busy_rule ? w_to_next : '0;
      if ((r_state == ST_INIT) && (r_init_cnt != '0))
        r_init_cnt <= r_init_cnt - INIT_W'(1);
      if (i_cnt_clr) begin
        r_stall_cnt   <= '0;
        r_flush_cnt   <= '0;
        r_mem_timeout <= 1'b0;
      end else begin
        if ((w_busy_rule || w_lu_rule) && (r_stall_cnt != '1))
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        if (w_take_rule && (r_flush_cnt != '1))
          r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        if (w_busy_rule && (w_to_next == TO_MAX))
          r_mem_timeout <= 1'b1;
      end
    end
  end

  assign o_pc_target   = i_ex_target;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;
  assign o_mem_timeout = r_mem_timeout;

endmodule
